// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port driver: command and response codes
// plus the driver state type.
package calc1_pkg;

   // Command codes carried on req_cmd_out during the first request cycle
   localparam logic [0:3] CMD_NOP = 4'd0;
   localparam logic [0:3] CMD_ADD = 4'd1;
   localparam logic [0:3] CMD_SUB = 4'd2;
   localparam logic [0:3] CMD_SHL = 4'd5;
   localparam logic [0:3] CMD_SHR = 4'd6;

   // Response codes returned by the DUV port
   localparam logic [0:1] RSP_NONE = 2'd0;
   localparam logic [0:1] RSP_SUCC = 2'd1;
   localparam logic [0:1] RSP_INOF = 2'd2;
   localparam logic [0:1] RSP_IERR = 2'd3;

   // Driver sequence: accept, command+op1, op2, wait for reply, report
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OP1,
      ST_OP2,
      ST_WAIT,
      ST_DONE
   } drv_state_t;

endpackage

// File: rtl/calc1_drv_timer.sv
// Clearable saturating cycle counter used to detect a missing DUV response.
// expired rises once the counter has reached LIMIT-1, so the owner sees it
// on the edge that would complete the LIMIT-th counted cycle.
module calc1_drv_timer #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] SAT_VALUE  = W'(LIMIT);
   localparam logic [W-1:0] LAST_VALUE = W'(LIMIT - 1);

   logic [W-1:0] count;

   // Count enabled cycles, clear has priority, stop at LIMIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != SAT_VALUE)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count >= LAST_VALUE);

endmodule

// File: rtl/calc1_port_driver.sv
// Request-side driver for one calc1 DUV port. Takes a transaction over a
// valid/ready handshake, sends command+op1 then op2 on the request pins,
// waits for the port response and reports it as a one-cycle pulse.
// Optional feature macro: CALC1_DRV_TIMEOUT_EN enables the response
// timeout (TIMEOUT_CYCLES); without it WAIT lasts until a reply arrives.
module calc1_port_driver
   import calc1_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        c_clk,
   input  logic        reset_n,
   input  logic        txn_valid,
   output logic        txn_ready,
   input  logic [0:3]  txn_cmd,
   input  logic [0:31] txn_op1,
   input  logic [0:31] txn_op2,
   output logic [0:3]  req_cmd_out,
   output logic [0:31] req_data_out,
   input  logic [0:1]  out_resp,
   input  logic [0:31] out_data,
   output logic        rsp_valid,
   output logic [0:1]  rsp_resp,
   output logic [0:31] rsp_data,
   output logic        rsp_timeout,
   output logic        stray_resp,
   output logic        busy
);

   drv_state_t  state;
   logic [0:3]  cmd_q;
   logic [0:31] op2_q;

   // A timeout below two cycles cannot cover the request-to-reply latency
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_too_small
   end

`ifdef CALC1_DRV_TIMEOUT_EN
   logic timer_expired;
   logic timeout_q;

   calc1_drv_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (c_clk),
      .rst_n   (reset_n),
      .clear   (state != ST_WAIT),
      .enable  (state == ST_WAIT),
      .expired (timer_expired)
   );

   assign rsp_timeout = timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   // Sequencer FSM; every output is registered alongside the next state
   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         cmd_q        <= '0;
         op2_q        <= '0;
         txn_ready    <= 1'b1;
         busy         <= 1'b0;
         req_cmd_out  <= '0;
         req_data_out <= '0;
         rsp_valid    <= 1'b0;
         rsp_resp     <= RSP_NONE;
         rsp_data     <= '0;
         stray_resp   <= 1'b0;
`ifdef CALC1_DRV_TIMEOUT_EN
         timeout_q    <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;

         if ((state != ST_WAIT) && (out_resp != RSP_NONE)) begin
            stray_resp <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (txn_valid) begin
                  cmd_q        <= txn_cmd;
                  op2_q        <= txn_op2;
                  req_cmd_out  <= txn_cmd;
                  req_data_out <= txn_op1;
                  txn_ready    <= 1'b0;
                  busy         <= 1'b1;
                  state        <= ST_OP1;
               end
            end

            ST_OP1: begin
               req_cmd_out <= '0;
               if (cmd_q == CMD_NOP) begin
                  req_data_out <= '0;
                  rsp_valid    <= 1'b1;
                  rsp_resp     <= RSP_NONE;
                  rsp_data     <= '0;
`ifdef CALC1_DRV_TIMEOUT_EN
                  timeout_q    <= 1'b0;
`endif
                  state        <= ST_DONE;
               end else begin
                  req_data_out <= op2_q;
                  state        <= ST_OP2;
               end
            end

            ST_OP2: begin
               req_cmd_out  <= '0;
               req_data_out <= '0;
               state        <= ST_WAIT;
            end

            ST_WAIT: begin
               if (out_resp != RSP_NONE) begin
                  rsp_valid <= 1'b1;
                  rsp_resp  <= out_resp;
                  rsp_data  <= out_data;
`ifdef CALC1_DRV_TIMEOUT_EN
                  timeout_q <= 1'b0;
`endif
                  state     <= ST_DONE;
               end
`ifdef CALC1_DRV_TIMEOUT_EN
               else if (timer_expired) begin
                  rsp_valid <= 1'b1;
                  rsp_resp  <= RSP_NONE;
                  rsp_data  <= '0;
                  timeout_q <= 1'b1;
                  state     <= ST_DONE;
               end
`endif
            end

            ST_DONE: begin
               txn_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end

            default: begin
               req_cmd_out  <= '0;
               req_data_out <= '0;
               txn_ready    <= 1'b1;
               busy         <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/calc1_port_driver.md
# calc1_port_driver

Request-side driver for one calc1 DUV port; the opposite end of the per-port response comparison done by the checker. It accepts a transaction from the testbench sequencer over a valid/ready handshake and serialises it onto the DUV request pins: command plus operand 1, then operand 2. It then waits for the DUV response and returns it to the bench as a one-cycle result pulse. The bench instantiates four of these, one per calc1 port. The reference model sees the same transaction stream.

## Interface
- TIMEOUT_CYCLES, 64: WAIT cycles tolerated before a response is declared missing (≥2).
- c_clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- txn_valid  in  1  bench offers a transaction.
- txn_ready  out  1  driver can accept; high only in IDLE.
- txn_cmd  in  [0:3]  calc1 command code.
- txn_op1, txn_op2  in  [0:31]  operands.
- req_cmd_out  out  [0:3]  to DUV req_cmd_in.
- req_data_out  out  [0:31]  to DUV req_data_in.
- out_resp  in  [0:1]  from DUV port response.
- out_data  in  [0:31]  from DUV port data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_resp  out  [0:1]  captured response code.
- rsp_data  out  [0:31]  captured response data.
- rsp_timeout  out  1  qualifies rsp_valid: no response arrived.
- stray_resp  out  1  sticky: nonzero out_resp arrived outside WAIT.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, OP1, OP2, WAIT, DONE.
- IDLE:
  - txn_ready=1.
  - On txn_valid, latch cmd, op1 and op2, then go to OP1.
- OP1:
  - req_cmd_out=cmd, req_data_out=op1.
  - If cmd=NOP (0), go to DONE with resp 0 and data 0.
  - Otherwise go to OP2.
- OP2: req_cmd_out=0, req_data_out=op2. Go to WAIT; timer cleared.
- WAIT:
  - Request pins are 0.
  - out_resp is sampled every posedge. If nonzero, capture out_resp and out_data, then go to DONE.
  - Otherwise the timer increments. When the timer reaches TIMEOUT_CYCLES, go to DONE with timeout=1, resp 0, data 0.
- DONE:
  - rsp_valid=1 for exactly one cycle; rsp_resp, rsp_data and rsp_timeout are driven from the captured registers.
  - Always return to IDLE.
  - No back-to-back accept: txn_ready stays 0 in DONE.
- Response codes passed through unmodified: 1 success, 2 invalid/overflow, 3 internal error.
- Command codes are not validated; invalid codes are sent as-is, because the DUV must reply with 2.
- stray_resp is set when out_resp≠0 in IDLE, OP1, OP2 or DONE, e.g. a late reply after a timeout. It is cleared only by reset.
- Outside DONE, rsp_resp, rsp_data and rsp_timeout hold their last values.

## Timing
- Reset (async assert, sync release):
  - State goes to IDLE.
  - req_cmd_out=0, req_data_out=0.
  - rsp_valid=0, rsp_resp=0, rsp_data=0, rsp_timeout=0.
  - stray_resp=0, busy=0, timer=0.
- Accept at edge N:
  - cmd and op1 are visible on the pins during N+1; op2 during N+2.
  - out_resp is first sampled at edge N+3.
- Response first sampled nonzero at edge M: rsp_valid is high during M+1. The earliest next accept is at edge M+2.
- Timeout: with no response, rsp_valid/rsp_timeout assert during cycle N+3+TIMEOUT_CYCLES.
- NOP: rsp_valid is high during N+2.
- Reset mid-transaction discards it without a rsp_valid, and the request pins drop to 0 immediately.
- All outputs are registered; there is no combinational path from DUV inputs to outputs.

## Configuration
- CALC1_DRV_TIMEOUT_EN defined:
  - The timer and TIMEOUT_CYCLES are active as described.
- CALC1_DRV_TIMEOUT_EN undefined:
  - No timer logic; WAIT persists until a response arrives.
  - rsp_timeout is tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Shared package calc1_pkg holds:
  - Command constants: CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6.
  - Response constants: RSP_NONE=0, RSP_SUCC=1, RSP_INOF=2, RSP_IERR=3.
  - The driver state enum.
- One sub-module, calc1_drv_timer:
  - Clearable saturating counter with an expired flag.
  - Instantiated only under CALC1_DRV_TIMEOUT_EN.

## Test plan
- ADD 5, 7:
  - req_cmd_out=1 and req_data_out=5, then 0 and 7.
  - DUV stub returns resp 1, data 12 three cycles later.
  - Expect rsp_valid for one cycle with resp 1, data 12 and timeout 0.
- Backpressure:
  - Hold txn_valid high with a second txn (SUB 9, 4) during an outstanding ADD.
  - Expect txn_ready=0 until IDLE; SUB is issued only after the ADD's rsp_valid, at edge M+2.
- Timeout, TIMEOUT_CYCLES=8:
  - Stub never responds.
  - Expect rsp_valid with rsp_timeout=1 and resp 0 in cycle N+11.
  - A later resp 1 from the stub sets stray_resp=1.
- NOP:
  - txn_cmd=0.
  - Expect the pins to show cmd 0 for one cycle, rsp_valid in cycle N+2 with resp 0, and no WAIT state.
- Reset in WAIT:
  - Assert reset_n=0 during WAIT, then release.
  - Expect all outputs at reset values, no rsp_valid, and a fresh ADD 1, 1 completing with data 2.
- Invalid cmd 3 with op1=0, op2=0:
  - Pins show cmd 3.
  - Stub returns resp 2; expect rsp_resp=2 passed through.
